counter_uart_tx: RTL and testbench



---
 rtl/counter_uart_tx_if.sv | 13 +
 rtl/counter_uart_tx.sv | 152 +++++++++++++++
 tb/tb_counter_uart_tx.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/counter_uart_tx_if.sv
// counter_uart_tx_if: connection between the counter stage and the serial reporter.
//   value_i   - 4-bit counter value (counter -> reporter)
//   uart_tx_o - serial TX line, idles high (reporter -> outside)
//   busy_o    - high while a character sequence is on the line (reporter -> outside)
// master: counter/observer side, slave: counter_uart_tx.
interface counter_uart_tx_if;
  logic [3:0] value_i;
  logic       uart_tx_o;
  logic       busy_o;

  modport master (output value_i, input uart_tx_o, input busy_o);
  modport slave  (input value_i, output uart_tx_o, output busy_o);
endinterface

// File: rtl/counter_uart_tx.sv
// counter_uart_tx: sends the 4-bit counter value as one ASCII hex character
// (8N1, LSB first) each time it changes; changes seen mid-sequence are
// coalesced into a single follow-up sequence carrying the latest value.
// Ports:
//   clock_i      - system clock, rising edge
//   reset_i      - asynchronous, active-high reset
//   bus (slave)  - value_i in; uart_tx_o, busy_o out (both registered)
// Parameter CLKS_PER_BIT (2..65535): clock cycles per UART bit.
// Optional build macro COUNTER_UART_CRLF_EN: every sequence becomes
// hex digit, CR, LF sent back-to-back with busy_o held high throughout.
module counter_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic               clock_i,
  input  logic               reset_i,
  counter_uart_tx_if.slave   bus
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic [3:0]        last_q;
  logic              pending_q;
  logic [7:0]        shift_q;
  logic [2:0]        bit_cnt;
  logic [BAUD_W-1:0] baud_cnt;
  logic              tx_q;
  logic              busy_q;
`ifdef COUNTER_UART_CRLF_EN
  logic [1:0]        seq_idx;
`endif

  logic       change_c;
  logic [2:0] next_bit_c;

  // Hex digit to ASCII: '0'..'9' then 'A'..'F'.
  function automatic logic [7:0] hex_ascii(input logic [3:0] v);
    return (v < 4'd10) ? (8'h30 + 8'(v)) : (8'h37 + 8'(v));
  endfunction

  assign change_c   = (bus.value_i != last_q);
  assign next_bit_c = 3'(bit_cnt + 3'd1);

  assign bus.uart_tx_o = tx_q;
  assign bus.busy_o    = busy_q;

  // Change detection, coalescing and the 8N1 framer.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= IDLE;
      last_q    <= 4'd0;
      pending_q <= 1'b0;
      shift_q   <= 8'd0;
      bit_cnt   <= 3'd0;
      baud_cnt  <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef COUNTER_UART_CRLF_EN
      seq_idx   <= 2'd0;
`endif
    end else begin
      if (change_c) begin
        last_q <= bus.value_i;
      end
      // Changes during a sequence only leave a flag; IDLE re-reads last_q.
      if (change_c && (state != IDLE)) begin
        pending_q <= 1'b1;
      end

      case (state)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (change_c || pending_q) begin
            // A fresh change wins over last_q, which is only updated this edge.
            shift_q   <= hex_ascii(change_c ? bus.value_i : last_q);
            pending_q <= 1'b0;
            baud_cnt  <= '0;
            bit_cnt   <= 3'd0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            state     <= START;
`ifdef COUNTER_UART_CRLF_EN
            seq_idx   <= 2'd0;
`endif
          end
        end

        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            tx_q     <= shift_q[0];
            state    <= DATA;
          end else begin
            baud_cnt <= BAUD_W'(baud_cnt + 1'b1);
          end
        end

        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= next_bit_c;
              tx_q    <= shift_q[next_bit_c];
            end
          end else begin
            baud_cnt <= BAUD_W'(baud_cnt + 1'b1);
          end
        end

        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
`ifdef COUNTER_UART_CRLF_EN
            if (seq_idx != 2'd2) begin
              // Chain CR then LF straight into the next start bit.
              shift_q <= (seq_idx == 2'd0) ? 8'h0D : 8'h0A;
              seq_idx <= 2'(seq_idx + 2'd1);
              tx_q    <= 1'b0;
              state   <= START;
            end else begin
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              state   <= IDLE;
            end
`else
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
`endif
          end else begin
            baud_cnt <= BAUD_W'(baud_cnt + 1'b1);
          end
        end

        default: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_uart_tx.sv
// tb_counter_uart_tx: scoreboard bench for counter_uart_tx with CLKS_PER_BIT=4.
// Expected characters are queued as value changes are driven; a line
// receiver decodes each frame at mid-bit and pops/compares. A busy monitor
// checks busy-high run lengths and records the idle gap between runs.
module tb_counter_uart_tx;

  localparam int unsigned C = 4;
`ifdef COUNTER_UART_CRLF_EN
  localparam int unsigned SEQ = 3;
`else
  localparam int unsigned SEQ = 1;
`endif

  logic clock_i = 1'b0;
  logic reset_i = 1'b1;

  counter_uart_tx_if bus ();

  counter_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clock_i = ~clock_i;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] sb_q[$];

  int         rx_pos    = 0;
  int         rx_frames = 0;
  int         rx_p      = 0;
  logic [7:0] rx_byte   = 8'd0;
  logic [7:0] rx_exp    = 8'd0;
  int         busy_run  = 0;
  int         busy_gap  = 0;
  int         last_gap  = -1;
  int         busy_cycles = 0;
  int         tx_low_cycles = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] ascii_of(input logic [3:0] v);
    logic [7:0] r;
    if (v <= 4'd9) r = 8'h30 + 8'(v);
    else           r = 8'h41 + 8'(v - 4'd10);
    return r;
  endfunction

  task automatic push_seq(input logic [3:0] v);
    sb_q.push_back(ascii_of(v));
`ifdef COUNTER_UART_CRLF_EN
    sb_q.push_back(8'h0D);
    sb_q.push_back(8'h0A);
`endif
  endtask

  // Receiver and busy monitor, sampled 1 time unit after each rising edge.
  initial forever begin
    @(posedge clock_i);
    #1;
    if (reset_i) begin
      rx_pos   = 0;
      busy_run = 0;
      busy_gap = 0;
    end else begin
      if (bus.busy_o)     busy_cycles++;
      if (!bus.uart_tx_o) tx_low_cycles++;

      if (rx_pos == 0) begin
        if (bus.uart_tx_o == 1'b0) rx_pos = 1;
      end else begin
        rx_p = rx_pos;
        rx_pos++;
        if (rx_p == int'(C / 2)) begin
          check_eq("start_bit", 32'(bus.uart_tx_o), 32'd0);
        end
        for (int k = 0; k < 8; k++) begin
          if (rx_p == int'(C * (k + 1) + C / 2)) rx_byte[k] = bus.uart_tx_o;
        end
        if (rx_p == int'(9 * C + C / 2)) begin
          check_eq("stop_bit", 32'(bus.uart_tx_o), 32'd1);
          check_eq("rx_expected", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            rx_exp = sb_q.pop_front();
            check_eq("rx_byte", 32'(rx_byte), 32'(rx_exp));
          end
          rx_frames++;
          rx_pos = 0;
        end
      end

      if (bus.busy_o) begin
        if (busy_run == 0) last_gap = busy_gap;
        busy_run++;
        busy_gap = 0;
      end else begin
        if (busy_run > 0) check_eq("busy_len", 32'(busy_run), 32'(SEQ * 10 * C));
        busy_run = 0;
        busy_gap++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock_i);
    #2;
  endtask

  task automatic set_value(input logic [3:0] v);
    @(negedge clock_i);
    bus.value_i = v;
  endtask

  // Bounded wait for the scoreboard to empty and the line to go idle.
  task automatic drain(input string tag);
    for (int k = 0; k < 2000; k++) begin
      if (sb_q.size() == 0 && !bus.busy_o && rx_pos == 0) break;
      tick(1);
    end
    check_eq(tag, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic pulse_reset(input logic [3:0] v);
    @(negedge clock_i);
    reset_i     = 1'b1;
    bus.value_i = v;
    sb_q.delete();
    tick(2);
    @(negedge clock_i);
    reset_i = 1'b0;
  endtask

  logic [3:0] vals[4];
  int f0;
  int b0;
  int t0;

  initial begin
    bus.value_i = 4'd0;
    vals[0] = 4'h9; vals[1] = 4'hA; vals[2] = 4'hF; vals[3] = 4'h0;

    // Reset state
    tick(2);
    check_eq("reset_tx", 32'(bus.uart_tx_o), 32'd1);
    check_eq("reset_busy", 32'(bus.busy_o), 32'd0);
    @(negedge clock_i);
    reset_i = 1'b0;
    tick(3);
    check_eq("idle_tx", 32'(bus.uart_tx_o), 32'd1);

    // Basic send 0 -> 5, start bit on the detecting edge
    f0 = rx_frames;
    set_value(4'd5);
    push_seq(4'd5);
    tick(1);
    check_eq("latency_tx", 32'(bus.uart_tx_o), 32'd0);
    check_eq("latency_busy", 32'(bus.busy_o), 32'd1);
    drain("basic_drain");
    check_eq("basic_frames", 32'(rx_frames - f0), 32'(SEQ));

    // Hex letters and wrap: 9, A, F, 0
    for (int i = 0; i < 4; i++) begin
      f0 = rx_frames;
      set_value(vals[i]);
      push_seq(vals[i]);
      drain("hex_drain");
      check_eq("hex_frames", 32'(rx_frames - f0), 32'(SEQ));
    end

    // Coalescing: 1 starts, 2 and 3 arrive during the frame; only '3' follows
    f0 = rx_frames;
    set_value(4'd1);
    push_seq(4'd1);
    tick(12);
    set_value(4'd2);
    tick(8);
    set_value(4'd3);
    push_seq(4'd3);
    drain("coal_drain");
    check_eq("coal_frames", 32'(rx_frames - f0), 32'(2 * SEQ));
    check_eq("coal_gap", 32'(last_gap), 32'd1);

    // Reset during data bit 3: line released without a clock edge
    set_value(4'd6);
    tick(1 + 4 * C + C / 2);
    #1;
    reset_i = 1'b1;
    sb_q.delete();
    #1;
    check_eq("midreset_tx", 32'(bus.uart_tx_o), 32'd1);
    check_eq("midreset_busy", 32'(bus.busy_o), 32'd0);
    bus.value_i = 4'd0;
    tick(2);
    @(negedge clock_i);
    reset_i = 1'b0;
    f0 = rx_frames;
    b0 = busy_cycles;
    tick(100);
    check_eq("post_reset0_frames", 32'(rx_frames - f0), 32'd0);
    check_eq("post_reset0_busy", 32'(busy_cycles - b0), 32'd0);

    // Nonzero value at release: transmission starts on the first edge
    pulse_reset(4'd7);
    f0 = rx_frames;
    push_seq(4'd7);
    tick(1);
    check_eq("reset7_tx", 32'(bus.uart_tx_o), 32'd0);
    check_eq("reset7_busy", 32'(bus.busy_o), 32'd1);
    drain("reset7_drain");
    check_eq("reset7_frames", 32'(rx_frames - f0), 32'(SEQ));

    // Held value: after the one report of 4, no further traffic
    pulse_reset(4'd4);
    push_seq(4'd4);
    drain("hold_first_drain");
    f0 = rx_frames;
    b0 = busy_cycles;
    t0 = tx_low_cycles;
    tick(500);
    check_eq("hold_frames", 32'(rx_frames - f0), 32'd0);
    check_eq("hold_busy", 32'(busy_cycles - b0), 32'd0);
    check_eq("hold_tx_low", 32'(tx_low_cycles - t0), 32'd0);
    check_eq("hold_tx", 32'(bus.uart_tx_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
